// File: rtl/fir_audio_sequencer.sv
// fir_audio_sequencer: pops a stereo pair from the codec, steps both FIR
// instances once, waits LAT cycles for the filtered result and pushes it back.
// Optional raw passthrough path is compiled in with `define FIR_SEQ_BYPASS_EN.
module fir_audio_sequencer #(
    parameter int unsigned W       = 24,
    parameter int unsigned LAT     = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_ready,
    input  logic [W-1:0] readdata_left,
    input  logic [W-1:0] readdata_right,
    output logic         read,
    input  logic         write_ready,
    output logic         write,
    output logic [W-1:0] writedata_left,
    output logic [W-1:0] writedata_right,
    output logic         fir_valid,
    output logic [W-1:0] fir_in_left,
    output logic [W-1:0] fir_in_right,
    input  logic [W-1:0] fir_out_left,
    input  logic [W-1:0] fir_out_right,
    input  logic         bypass,
    output logic [15:0]  sample_count,
    output logic         overrun
);

    localparam int unsigned WCW = $clog2(LAT + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FILTER, WAIT, WRITE} state_t;

    state_t         state, state_next;
    logic [WCW-1:0] wcnt, wcnt_next;
    logic [TCW-1:0] tcnt, tcnt_next;
    logic           cap_in, cap_out, cap_raw, drop;
    logic           use_bypass;

`ifdef FIR_SEQ_BYPASS_EN
    assign use_bypass = bypass;
`else
    logic unused_bypass;
    assign unused_bypass = bypass;
    assign use_bypass    = 1'b0;
`endif

    // Pop strobe follows the codec handshake in the same cycle; held low in reset
    assign read = (state == IDLE) && read_ready && reset;

    // Next-state, counter and load-enable decode
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        tcnt_next  = '0;
        cap_in     = 1'b0;
        cap_out    = 1'b0;
        cap_raw    = 1'b0;
        drop       = 1'b0;
        write      = 1'b0;
        case (state)
            IDLE: begin
                if (read) begin
                    if (use_bypass) begin
                        cap_raw    = 1'b1;
                        state_next = WRITE;
                    end else begin
                        cap_in     = 1'b1;
                        state_next = FILTER;
                    end
                end
            end
            FILTER: begin
                wcnt_next  = WCW'(LAT);
                state_next = WAIT;
            end
            WAIT: begin
                if (wcnt == WCW'(1)) begin
                    cap_out    = 1'b1;
                    wcnt_next  = '0;
                    state_next = WRITE;
                end else begin
                    wcnt_next = wcnt - WCW'(1);
                end
            end
            WRITE: begin
                if (write_ready) begin
                    write      = 1'b1;
                    state_next = IDLE;
                end else if (tcnt == TCW'(TIMEOUT - 1)) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + TCW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and registered datapath outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wcnt            <= '0;
            tcnt            <= '0;
            fir_valid       <= 1'b0;
            fir_in_left     <= '0;
            fir_in_right    <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            sample_count    <= '0;
            overrun         <= 1'b0;
        end else begin
            state     <= state_next;
            wcnt      <= wcnt_next;
            tcnt      <= tcnt_next;
            fir_valid <= (state_next == FILTER);
            if (cap_in) begin
                fir_in_left  <= readdata_left;
                fir_in_right <= readdata_right;
            end
            if (cap_out) begin
                writedata_left  <= fir_out_left;
                writedata_right <= fir_out_right;
            end else if (cap_raw) begin
                writedata_left  <= readdata_left;
                writedata_right <= readdata_right;
            end
            if (write) begin
                sample_count <= sample_count + 16'd1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_audio_sequencer.sv
// Directed bench for fir_audio_sequencer with a behavioural LAT=1 filter stub
// (halving mode or 4-tap moving average). Honours `define FIR_SEQ_BYPASS_EN.
module tb_fir_audio_sequencer;

    localparam int unsigned W = 24;

    logic         clk = 1'b0;
    logic         reset;
    logic         read_ready, write_ready, bypass;
    logic [W-1:0] readdata_left, readdata_right;
    logic         read, write, fir_valid, overrun;
    logic [W-1:0] writedata_left, writedata_right;
    logic [W-1:0] fir_in_left, fir_in_right;
    logic [W-1:0] fir_out_left, fir_out_right;
    logic [15:0]  sample_count;

    int total = 0;
    int bad   = 0;

    fir_audio_sequencer #(.W(W), .LAT(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .read_ready(read_ready), .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(read), .write_ready(write_ready), .write(write),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .fir_valid(fir_valid), .fir_in_left(fir_in_left), .fir_in_right(fir_in_right),
        .fir_out_left(fir_out_left), .fir_out_right(fir_out_right),
        .bypass(bypass), .sample_count(sample_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter: a cycle is numbered by the rising edge that starts it
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Filter stub: one-cycle latency, window steps only on fir_valid
    logic avg_mode = 1'b0;
    int   hl_l[3] = '{0, 0, 0};
    int   hl_r[3] = '{0, 0, 0};
    int   fin_l, fin_r, sum_l, sum_r;
    assign fin_l = int'($signed(fir_in_left));
    assign fin_r = int'($signed(fir_in_right));
    assign sum_l = fin_l + hl_l[0] + hl_l[1] + hl_l[2];
    assign sum_r = fin_r + hl_r[0] + hl_r[1] + hl_r[2];
    always @(posedge clk) begin
        if (fir_valid) begin
            fir_out_left  <= avg_mode ? W'(sum_l >>> 2) : W'(fin_l >>> 1);
            fir_out_right <= avg_mode ? W'(sum_r >>> 2) : W'(fin_r >>> 1);
            hl_l[0] <= fin_l; hl_l[1] <= hl_l[0]; hl_l[2] <= hl_l[1];
            hl_r[0] <= fin_r; hl_r[1] <= hl_r[0]; hl_r[2] <= hl_r[1];
        end
    end

    // Strobe monitor, sampled mid-cycle: event counts, last times, exclusivity
    int   n_read = 0, n_fv = 0, n_write = 0, viol = 0;
    int   t_read = -1, t_fv = -1, t_write = -1;
    logic p_read = 1'b0, p_fv = 1'b0, p_write = 1'b0;
    always @(negedge clk) begin
        if (read)      begin n_read  <= n_read + 1;  t_read  <= cyc; end
        if (fir_valid) begin n_fv    <= n_fv + 1;    t_fv    <= cyc; end
        if (write)     begin n_write <= n_write + 1; t_write <= cyc; end
        if ((int'(read) + int'(fir_valid) + int'(write)) > 1 ||
            (read && p_read) || (fir_valid && p_fv) || (write && p_write))
            viol <= viol + 1;
        p_read  <= read;
        p_fv    <= fir_valid;
        p_write <= write;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) tick();
    endtask

    // Wait (bounded) for a pop; returns its cycle, leaves us at start of the next cycle
    task automatic wait_read(input string tag, output int t);
        t = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (read) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({tag, "_read_seen"}, 32'd0, 32'd1);
        tick();
    endtask

    // Wait (bounded) for a push; returns its cycle, leaves us after the write edge
    task automatic wait_write(input string tag, input int budget, output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (write) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({tag, "_write_seen"}, 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int t, tw, rel, nr0, nw0, nf0, tprev, gap;

        // Reset held with a pair pending: nothing may move
        reset = 1'b0; read_ready = 1'b1; write_ready = 1'b1; bypass = 1'b0;
        readdata_left = W'(160); readdata_right = W'(320);
        repeat (4) tick();
        check("rst_read", 32'(read), 32'd0);
        check("rst_read_cnt", 32'(n_read), 32'd0);
        check("rst_outputs", {16'(sample_count), 7'd0, overrun, write, fir_valid, 6'd0},
              32'd0);
        check("rst_wd_l", 32'(writedata_left), 32'd0);
        check("rst_fin_l", 32'(fir_in_left), 32'd0);

        // Release: pop in the very first cycle, filtered write at T+3
        reset = 1'b1;
        rel = cyc;
        wait_read("lat", t);
        read_ready = 1'b0;
        check("lat_read_t", 32'(t), 32'(rel));
        wait_write("lat", 10, tw);
        check("lat_fv_t", 32'(t_fv), 32'(t + 1));
        check("lat_fv_cnt", 32'(n_fv), 32'd1);
        check("lat_write_t", 32'(tw), 32'(t + 3));
        check("lat_wd_l", 32'(writedata_left), 32'd80);
        check("lat_wd_r", 32'(writedata_right), 32'd160);
        check("lat_count", 32'(sample_count), 32'd1);
        check("lat_fin_l", 32'(fir_in_left), 32'd160);

        // Back-pressure until the last WRITE cycle: write wins over timeout
        write_ready = 1'b0; read_ready = 1'b1;
        readdata_left = W'(100); readdata_right = W'(200);
        nr0 = n_read; nw0 = n_write;
        wait_read("bp", t);
        to_cycle(t + 10);
        check("bp_no_write_yet", 32'(n_write), 32'(nw0));
        write_ready = 1'b1;
        wait_write("bp", 4, tw);
        read_ready = 1'b0;
        check("bp_write_t", 32'(tw), 32'(t + 10));
        check("bp_single_read", 32'(n_read - nr0), 32'd1);
        check("bp_overrun", 32'(overrun), 32'd0);
        check("bp_wd_l", 32'(writedata_left), 32'd50);
        check("bp_count", 32'(sample_count), 32'd2);

        // Timeout: pair dropped after 8 WRITE cycles, FSM back in IDLE
        write_ready = 1'b0; read_ready = 1'b1;
        readdata_left = W'(300); readdata_right = W'(600);
        nw0 = n_write;
        wait_read("to", t);
        read_ready = 1'b0;
        to_cycle(t + 10);
        check("to_overrun_before", 32'(overrun), 32'd0);
        to_cycle(t + 11);
        check("to_overrun_set", 32'(overrun), 32'd1);
        check("to_no_write", 32'(n_write), 32'(nw0));
        read_ready = 1'b1; write_ready = 1'b1;
        readdata_left = W'(80); readdata_right = W'(160);
        wait_read("to_next", tw);
        read_ready = 1'b0;
        check("to_idle_pop_t", 32'(tw), 32'(t + 11));
        t = tw;
        wait_write("to_next", 10, tw);
        check("to_next_write_t", 32'(tw), 32'(t + 3));
        check("to_next_wd_r", 32'(writedata_right), 32'd80);
        check("to_overrun_sticky", 32'(overrun), 32'd1);
        check("to_count", 32'(sample_count), 32'd3);

        // Stream 20 pairs through the 4-tap moving average
        avg_mode = 1'b1; write_ready = 1'b1; read_ready = 1'b1;
        readdata_left = W'(480); readdata_right = W'(-480);
        nf0 = n_fv; nw0 = n_write; tprev = -1; gap = 0;
        for (int i = 0; i < 20; i++) begin
            wait_read("stream", t);
            if (tprev >= 0) gap = t - tprev;
            tprev = t;
        end
        read_ready = 1'b0;
        for (int k = 0; k < 20 && n_write < nw0 + 20; k++) tick();
        tick();
        check("stream_fv_cnt", 32'(n_fv - nf0), 32'd20);
        check("stream_write_cnt", 32'(n_write - nw0), 32'd20);
        check("stream_period", 32'(gap), 32'd4);
        check("stream_wd_l", 32'(writedata_left), 32'd480);
        check("stream_wd_r", 32'(writedata_right), 32'h00FF_FE20);
        check("stream_count", 32'(sample_count), 32'd23);

        // Bypass request on a single pair
        avg_mode = 1'b0; bypass = 1'b1; write_ready = 1'b1; read_ready = 1'b1;
        readdata_left = W'(640); readdata_right = W'(1280);
        nf0 = n_fv;
        wait_read("byp", t);
        read_ready = 1'b0;
        bypass = 1'b0;
        wait_write("byp", 10, tw);
`ifdef FIR_SEQ_BYPASS_EN
        check("byp_write_t", 32'(tw), 32'(t + 1));
        check("byp_fv_cnt", 32'(n_fv - nf0), 32'd0);
        check("byp_wd_l", 32'(writedata_left), 32'd640);
        check("byp_wd_r", 32'(writedata_right), 32'd1280);
`else
        check("byp_write_t", 32'(tw), 32'(t + 3));
        check("byp_fv_cnt", 32'(n_fv - nf0), 32'd1);
        check("byp_wd_l", 32'(writedata_left), 32'd320);
        check("byp_wd_r", 32'(writedata_right), 32'd640);
`endif
        check("byp_count", 32'(sample_count), 32'd24);

        // Reset mid-pair aborts it without a write
        write_ready = 1'b0; read_ready = 1'b1;
        readdata_left = W'(500); readdata_right = W'(700);
        nw0 = n_write;
        wait_read("mid", t);
        read_ready = 1'b0;
        to_cycle(t + 2);
        reset = 1'b0;
        write_ready = 1'b1;
        tick();
        check("mid_count", 32'(sample_count), 32'd0);
        check("mid_overrun", 32'(overrun), 32'd0);
        check("mid_wd_l", 32'(writedata_left), 32'd0);
        check("mid_fin_r", 32'(fir_in_right), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();
        check("mid_no_write", 32'(n_write - nw0), 32'd0);
        check("strobe_protocol", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_audio_sequencer.md
# fir_audio_sequencer

Control block that sequences the stereo FIR moving-average datapath against the audio codec handshake. It pops one left/right sample pair from the codec, strobes both FIR filter instances with a single-cycle valid pulse, waits a configured pipeline latency, and pushes the filtered pair back to the codec. It also counts written samples and flags stalls on the output side. It sits between the codec interface and the two FIR_Filter instances in the Task 3 top level.

## Interface
Parameters:
- W, 24, sample width (signed) for all data buses
- LAT, 1, cycles from fir_valid to valid fir_out; must be >= 1
- TIMEOUT, 1024, max cycles to wait for write_ready before dropping the pair

Ports:
- clk  in  1  system clock; everything is rising-edge
- reset  in  1  asynchronous, active-low reset
- read_ready  in  1  codec has an input pair available
- readdata_left / readdata_right  in  W  codec input samples, valid while read_ready=1
- read  out  1  one-cycle pop strobe to codec
- write_ready  in  1  codec can accept an output pair
- write  out  1  one-cycle push strobe to codec
- writedata_left / writedata_right  out  W  registered output samples
- fir_valid  out  1  shared isValid strobe to both FIR instances
- fir_in_left / fir_in_right  out  W  registered samples to FIR dataIn
- fir_out_left / fir_out_right  in  W  FIR dataOut
- bypass  in  1  raw passthrough request (see Configuration)
- sample_count  out  16  written pairs, wraps 0xFFFF -> 0
- overrun  out  1  sticky: a pair was dropped on write timeout

## Operation
- FSM states: IDLE, FILTER, WAIT, WRITE.
- IDLE: if read_ready=1, assert read for that cycle, capture readdata_* into fir_in_*, go FILTER.
- FILTER: fir_valid=1 for exactly this cycle; load wait counter with LAT; go WAIT.
- WAIT: decrement each cycle; on the last WAIT cycle, capture fir_out_* into writedata_*, go WRITE.
- WRITE: in the first cycle with write_ready=1, assert write, increment sample_count, go IDLE. If TIMEOUT cycles pass with write_ready=0, set overrun, do not write, go IDLE.
- read, write, fir_valid are never asserted in the same cycle and are never high for two consecutive cycles.
- The FIR filters are stepped exactly once per popped pair, so their windows advance only on real samples.
- read_ready is ignored outside IDLE. The codec FIFO absorbs back-pressure.
- overrun clears only on reset.
- Reset values: read=0, write=0, fir_valid=0, fir_in_*=0, writedata_*=0, sample_count=0, overrun=0, state=IDLE, wait and timeout counters=0. Reset asserted mid-operation aborts the pair with no write.

## Timing
- Pop at cycle T. fir_valid at T+1. WAIT covers T+2..T+1+LAT, with capture at the edge ending T+1+LAT. Earliest write is at T+2+LAT.
- With LAT=1: read T, fir_valid T+1, write T+3. Minimum period is 4 cycles per pair.
- Timeout counter starts at entry to WRITE. Drop occurs at the end of cycle TIMEOUT in WRITE.
- If write_ready rises in the same cycle the timeout expires, the write wins and overrun stays 0.
- sample_count and writedata_* are registered and update on the edge that ends the write cycle or the capture cycle.

## Configuration
- FIR_SEQ_BYPASS_EN defined:
  - With bypass=1 sampled in IDLE at the pop, the FSM goes IDLE -> WRITE directly.
  - writedata_* take the raw readdata_*; fir_valid is not pulsed, so the filter windows are untouched.
  - Earliest write is at T+1.
- Not defined: the bypass port exists but is ignored, and all pairs are filtered.

## Test plan
- Reset: hold reset=0 with read_ready=1. All outputs stay 0 and no read pulses occur. Release reset -> read at the first cycle with read_ready=1.
- Latency, using a stub filter with LAT=1 and fir_out=fir_in>>1: pop left=160, right=320 at T with write_ready=1 -> fir_valid only at T+1, write at T+3, writedata=80/160, sample_count=1.
- Back-pressure: write_ready=0 for 10 cycles, then 1 -> exactly one write on the first ready cycle. No second read occurs before that write. overrun=0.
- Timeout: TIMEOUT=8, write_ready held 0 -> no write, overrun=1 after 8 WRITE cycles, FSM back in IDLE. The next pair writes normally and overrun stays 1.
- Stream with real FIR_Filter (n=4): 20 pairs of 480 with read_ready and write_ready always 1 -> 20 fir_valid pulses and 20 writes. The final writedata equals the filter's steady-state output for constant 480. sample_count=20.
- With FIR_SEQ_BYPASS_EN and bypass=1: pop 640 -> write at T+1 with writedata=640 and no fir_valid. Without the macro, the same stimulus gives the filtered path timing.
